data_connect_pipe_chain: RTL and testbench

DATA_CONNECT_PIPE_CHAIN -- requirements
Module: data_connect_pipe_chain

---
 rtl/data_connect_pipe_chain.sv | 83 ++++++++
 tb/tb_data_connect_pipe_chain.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_connect_pipe_chain.sv
// data_connect_pipe_chain: cascade of DEPTH two-entry skid-buffer stages with registered ready,
// flush, global enable and an occupancy count.
module data_connect_pipe_chain #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 2,
    parameter int CSIZE = $clog2(2*DEPTH+1)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             from_up_vld,
    input  logic [DSIZE-1:0] from_up_data,
    output logic             to_up_ready,
    input  logic             from_down_ready,
    output logic             to_down_vld,
    output logic [DSIZE-1:0] to_down_data,
    output logic [CSIZE-1:0] count
);
    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

    state_t           state_q [DEPTH];
    state_t           state_d [DEPTH];
    logic [DSIZE-1:0] main_q  [DEPTH];
    logic [DSIZE-1:0] main_d  [DEPTH];
    logic [DSIZE-1:0] skid_q  [DEPTH];
    logic [DSIZE-1:0] skid_d  [DEPTH];
    logic [DSIZE-1:0] dat_c   [DEPTH+1];
    logic [DEPTH-1:0] rdy_q, rdy_d;
    logic [DEPTH:0]   vld_c, rdy_c, fire;
    logic [CSIZE-1:0] count_q, count_d;

    // Link s is the boundary feeding stage s; link DEPTH is the chain output.
    always_comb begin
        vld_c[0] = from_up_vld;
        dat_c[0] = from_up_data;
        for (int s = 0; s < DEPTH; s++) begin
            vld_c[s+1] = state_q[s] != EMPTY;
            dat_c[s+1] = main_q[s];
            rdy_c[s]   = rdy_q[s];
        end
        rdy_c[DEPTH] = from_down_ready;
        for (int s = 0; s <= DEPTH; s++)
            fire[s] = clk_en && !flush && vld_c[s] && rdy_c[s];
        for (int s = 0; s < DEPTH; s++) begin
            state_d[s] = flush ? EMPTY :
                         state_q[s] == EMPTY ? (fire[s] ? HALF : EMPTY) :
                         state_q[s] == HALF  ? ((fire[s] && !fire[s+1]) ? FULL :
                                                (!fire[s] && fire[s+1]) ? EMPTY : HALF) :
                         (fire[s+1] ? HALF : FULL);
            main_d[s]  = (fire[s] && (state_q[s] == EMPTY || fire[s+1])) ? dat_c[s] :
                         (state_q[s] == FULL && fire[s+1]) ? skid_q[s] : main_q[s];
            skid_d[s]  = (state_q[s] == HALF && fire[s] && !fire[s+1]) ? dat_c[s] : skid_q[s];
            rdy_d[s]   = state_d[s] != FULL;
        end
        count_d = flush ? '0 : count_q + CSIZE'(fire[0]) - CSIZE'(fire[DEPTH]);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                state_q[s] <= EMPTY;
                main_q[s]  <= '0;
                skid_q[s]  <= '0;
            end
            rdy_q   <= '0;
            count_q <= '0;
        end else if (clk_en) begin
            for (int s = 0; s < DEPTH; s++) begin
                state_q[s] <= state_d[s];
                main_q[s]  <= main_d[s];
                skid_q[s]  <= skid_d[s];
            end
            rdy_q   <= rdy_d;
            count_q <= count_d;
        end
    end

    assign to_up_ready  = clk_en && rdy_q[0];
    assign to_down_vld  = clk_en && state_q[DEPTH-1] != EMPTY;
    assign to_down_data = main_q[DEPTH-1];
    assign count        = count_q;
endmodule

// File: tb/tb_data_connect_pipe_chain.sv
// tb_data_connect_pipe_chain: directed vector table, hand sequences and a FIFO scoreboard
// for the DSIZE=8, DEPTH=3 pipe chain.
module tb_data_connect_pipe_chain;
    localparam int DSIZE = 8;
    localparam int DEPTH = 3;
    localparam int CSIZE = $clog2(2*DEPTH+1);
    localparam int CAP   = 2*DEPTH;

    logic             clock = 0;
    logic             rst_n = 0;
    logic             clk_en = 1;
    logic             flush = 0;
    logic             from_up_vld = 0;
    logic [DSIZE-1:0] from_up_data = '0;
    logic             to_up_ready;
    logic             from_down_ready = 0;
    logic             to_down_vld;
    logic [DSIZE-1:0] to_down_data;
    logic [CSIZE-1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    data_connect_pipe_chain #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
        .clock(clock), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
        .from_up_vld(from_up_vld), .from_up_data(from_up_data), .to_up_ready(to_up_ready),
        .from_down_ready(from_down_ready), .to_down_vld(to_down_vld),
        .to_down_data(to_down_data), .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard: behavioural FIFO of accepted words plus a reference occupancy count.
    logic [DSIZE-1:0] sbq[$];
    int               mcnt = 0;

    always @(negedge clock) begin
        if (!rst_n) begin
            sbq.delete();
            mcnt = 0;
        end else begin
            check("sb_count", 32'(count), 32'(mcnt));
            if (to_down_vld) begin
                if (sbq.size() == 0) check("sb_spurious_vld", 32'(to_down_vld), 32'd0);
                else check("sb_data", 32'(to_down_data), 32'(sbq[0]));
            end
            if (clk_en && mcnt == CAP) check("sb_full_ready", 32'(to_up_ready), 32'd0);
            if (clk_en && flush) begin
                sbq.delete();
                mcnt = 0;
            end else if (clk_en) begin
                if (to_down_vld && from_down_ready && sbq.size() > 0) begin
                    void'(sbq.pop_front());
                    mcnt--;
                end
                if (from_up_vld && to_up_ready) begin
                    sbq.push_back(from_up_data);
                    mcnt++;
                end
            end
        end
    end

    typedef struct {
        logic             vld;
        logic [DSIZE-1:0] d;
        logic             drdy;
        logic             fl;
        logic             e_rdy;
        logic             e_vld;
        logic [DSIZE-1:0] e_d;
        int               e_cnt;
    } vec_t;

    task automatic drive(input logic v, input logic [DSIZE-1:0] d, input logic dr, input logic fl);
        @(posedge clock);
        #1;
        from_up_vld = v;
        from_up_data = d;
        from_down_ready = dr;
        flush = fl;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        int   acc;
        int   outs;
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        tbl[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2};
        tbl[8]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3};
        tbl[9]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 4};
        for (int i = 10; i < 14; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'(to_up_ready), 0);
        check("rst_vld", 32'(to_down_vld), 0);
        check("rst_data", 32'(to_down_data), 0);
        check("rst_count", 32'(count), 0);
        @(posedge clock);
        #1 rst_n = 1;
        @(negedge clock);
        check("post_rst_ready_low", 32'(to_up_ready), 0);

        // Single word, then flush with four words held
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].vld, tbl[i].d, tbl[i].drdy, tbl[i].fl);
            @(negedge clock);
            check($sformatf("tbl%0d_ready", i), 32'(to_up_ready), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_vld", i), 32'(to_down_vld), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) check($sformatf("tbl%0d_data", i), 32'(to_down_data), 32'(tbl[i].e_d));
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
        end

        // Back-to-back stream: first output at cycle DEPTH, then one per cycle
        for (int c = 0; c < 104; c++) begin
            drive(c < 100, DSIZE'(c), 1'b1, 1'b0);
            @(negedge clock);
            if (c < 100) check("stream_ready", 32'(to_up_ready), 1);
            check("stream_vld", 32'(to_down_vld), 32'(c >= DEPTH && c < 100 + DEPTH));
            if (c >= DEPTH && c < 100 + DEPTH) check("stream_data", 32'(to_down_data), 32'(c - DEPTH));
        end

        // Backpressure: fill to capacity, then drain
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, DSIZE'(8'hB0 + acc), 1'b0, 1'b0);
            @(negedge clock);
            if (to_up_ready) acc++;
        end
        check("bp_accepted", 32'(acc), CAP);
        check("bp_count", 32'(count), CAP);
        check("bp_ready", 32'(to_up_ready), 0);
        outs = 0;
        for (int c = 0; c < 30 && outs < CAP; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            @(negedge clock);
            if (to_down_vld) outs++;
        end
        check("bp_drained", 32'(outs), CAP);
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clock);
        check("bp_count_empty", 32'(count), 0);

        // Enable freeze with three words held and traffic on the inputs
        for (int k = 0; k < 3; k++) drive(1'b1, DSIZE'(8'h51 + k), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        clk_en = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("frz_count", 32'(count), 3);
            check("frz_data", 32'(to_down_data), 32'h51);
            check("frz_ready", 32'(to_up_ready), 0);
            check("frz_vld", 32'(to_down_vld), 0);
            @(posedge clock);
        end
        #1 clk_en = 1;
        from_up_vld = 0;
        repeat (8) drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clock);
        check("frz_drain_count", 32'(count), 0);

        // Mid-stream asynchronous reset
        for (int c = 0; c < 6; c++) drive(1'b1, DSIZE'(8'hC0 + c), 1'b0, 1'b0);
        @(posedge clock);
        #2 rst_n = 0;
        from_up_vld = 0;
        #1;
        check("mrst_vld", 32'(to_down_vld), 0);
        check("mrst_data", 32'(to_down_data), 0);
        check("mrst_count", 32'(count), 0);
        check("mrst_ready", 32'(to_up_ready), 0);
        @(negedge clock);
        @(posedge clock);
        #1 rst_n = 1;
        @(negedge clock);
        check("mrst_ready_hold", 32'(to_up_ready), 0);
        @(negedge clock);
        check("mrst_ready_rise", 32'(to_up_ready), 1);

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++)
            drive(1'($urandom_range(0, 1)), DSIZE'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 199) == 0);
        for (int c = 0; c < 12; c++) drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clock);
        check("final_count", 32'(count), 0);
        check("final_queue", 32'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
